// File: rtl/bin_morph.sv
// 3x3 binary morphology (erosion, or dilation when BIN_MORPH_DILATE_EN is defined)
// over a raster stream, with two line buffers and a fixed 2-clock output latency.
module bin_morph #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_vld,
  input  logic din_sop,
  input  logic din_eop,
  output logic dout,
  output logic dout_vld,
  output logic dout_sop,
  output logic dout_eop
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          restart;
  logic          frame_start;
  logic          lb1 [IMG_W];
  logic          lb2 [IMG_W];
  logic [2:0]    col_new, win_c1, win_c2;
  logic          op_res, border;
  logic          d1, v1, s1, e1;
  logic          d2, v2, s2, e2;

  // A sop pixel, or the pixel right after an eop, is always (0,0).
  always_comb begin
    frame_start = din_sop | restart;
    cur_col     = frame_start ? '0 : col;
    cur_row     = frame_start ? '0 : row;
    col_new     = {lb2[cur_col], lb1[cur_col], din};
    border      = (cur_row[RW-1:1] == '0) || (cur_col[CW-1:1] == '0);
`ifdef BIN_MORPH_DILATE_EN
    op_res      = |{win_c2, win_c1, col_new};
`else
    op_res      = &{win_c2, win_c1, col_new};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      restart <= 1'b0;
    end else if (din_vld) begin
      restart <= din_eop;
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? ROW_LAST : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line buffers are deliberately unreset; stale bits only reach masked border positions.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      lb1[cur_col] <= din;
      lb2[cur_col] <= lb1[cur_col];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_c1 <= '0;
      win_c2 <= '0;
    end else if (din_vld) begin
      win_c2 <= win_c1;
      win_c1 <= col_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 1'b0;
      v1 <= 1'b0;
      s1 <= 1'b0;
      e1 <= 1'b0;
      d2 <= 1'b0;
      v2 <= 1'b0;
      s2 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      d1 <= din_vld & ~border & op_res;
      v1 <= din_vld;
      s1 <= din_sop;
      e1 <= din_eop;
      d2 <= d1;
      v2 <= v1;
      s2 <= s1;
      e2 <= e1;
    end
  end

  assign dout     = d2 & v2;
  assign dout_vld = v2;
  assign dout_sop = s2;
  assign dout_eop = e2;

endmodule

// File: tb/tb_bin_morph.sv
// Randomized bench for bin_morph against a frame-level behavioural model (8x6 image).
module tb_bin_morph;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0, din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic dout, dout_vld, dout_sop, dout_eop;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {logic d; logic v; logic s; logic e;} pix_t;
  pix_t       stim[$];
  logic [3:0] obs[$];
  logic [3:0] exp_out[$];

  // model state: next column, line index since frame start, history of lines
  int m_c, m_li;
  bit m_restart;
  bit m_cur[W], m_l1[W], m_l2[W];

  bin_morph #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_c = 0;
    m_li = 0;
    m_restart = 1'b1;
  endfunction

  function automatic bit model_pixel(bit d, bit s, bit e);
    bit acc;
    int r;
    if (s || m_restart) begin
      m_c = 0;
      m_li = 0;
    end
    r = (m_li < H - 1) ? m_li : H - 1;
    m_cur[m_c] = d;
`ifdef BIN_MORPH_DILATE_EN
    acc = 1'b0;
    for (int k = 0; k < 3; k++)
      if (m_c - k >= 0) acc = acc | m_cur[m_c-k] | m_l1[m_c-k] | m_l2[m_c-k];
`else
    acc = 1'b1;
    for (int k = 0; k < 3; k++)
      if (m_c - k >= 0) acc = acc & m_cur[m_c-k] & m_l1[m_c-k] & m_l2[m_c-k];
`endif
    if (r < 2 || m_c < 2) acc = 1'b0;
    if (m_c == W - 1) begin
      m_l2 = m_l1;
      m_l1 = m_cur;
      m_c = 0;
      m_li++;
    end else begin
      m_c++;
    end
    m_restart = e;
    return acc;
  endfunction

  task automatic add_pix(bit d, bit s, bit e);
    pix_t p;
    p.d = d; p.v = 1'b1; p.s = s; p.e = e;
    stim.push_back(p);
  endtask

  task automatic add_idle();
    stim.push_back(4'b0000);
  endtask

  // kind: 0 all ones, 1 single dot at (3,3), 2 random; gap: 0 none, 1 every other, 2 random
  task automatic add_frame(int kind, int gap, int lines);
    bit d;
    for (int r = 0; r < lines; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0: d = 1'b1;
          1: d = (r == 3 && c == 3);
          default: d = ($urandom_range(0, 3) != 0);
        endcase
        add_pix(d, (r == 0 && c == 0), (r == lines - 1 && c == W - 1));
        if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) add_idle();
      end
  endtask

  function automatic void build_expected();
    bit val;
    exp_out.delete();
    exp_out.push_back(4'b0);
    exp_out.push_back(4'b0);
    foreach (stim[i]) begin
      val = stim[i].v ? model_pixel(stim[i].d, stim[i].s, stim[i].e) : 1'b0;
      exp_out.push_back({stim[i].v, stim[i].s, stim[i].e, stim[i].v & val});
    end
  endfunction

  // obs[j+2] holds the outputs belonging to stim[j]
  task automatic run();
    obs.delete();
    for (int j = 0; j < stim.size() + 2; j++) begin
      @(negedge clk);
      obs.push_back({dout_vld, dout_sop, dout_eop, dout});
      if (j < stim.size()) begin
        din = stim[j].d; din_vld = stim[j].v; din_sop = stim[j].s; din_eop = stim[j].e;
      end else begin
        din = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    din = 1'b1; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout got=%b exp=0", dout); end
    if (dout_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got=%b exp=0", dout_vld); end
    if (dout_sop !== 1'b0) begin miscompares++; $display("FAIL reset_sop got=%b exp=0", dout_sop); end
    if (dout_eop !== 1'b0) begin miscompares++; $display("FAIL reset_eop got=%b exp=0", dout_eop); end
    din = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int ones, vlds;
    stim.delete();
    add_frame(0, 0, H);
    build_expected();
    run();
    ones = 0; vlds = 0;
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL all_ones cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
      ones += obs[j][0];
      vlds += obs[j][3];
    end
    vectors += 2;
    if (ones != 24) begin miscompares++; $display("FAIL all_ones_count got=%0d exp=24", ones); end
    if (vlds != W * H) begin miscompares++; $display("FAIL all_ones_vld got=%0d exp=%0d", vlds, W * H); end
  endtask

  task automatic test_single_dot();
    int ones, want;
`ifdef BIN_MORPH_DILATE_EN
    want = 9;
`else
    want = 0;
`endif
    stim.delete();
    add_frame(1, 0, H);
    build_expected();
    run();
    ones = 0;
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL single_dot cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
      ones += obs[j][0];
    end
    vectors++;
    if (ones != want) begin miscompares++; $display("FAIL single_dot_count got=%0d exp=%0d", ones, want); end
  endtask

  task automatic test_back_to_back();
    int first_vld, eop_at, nvld;
    stim.delete();
    add_frame(0, 0, H);
    add_frame(2, 0, H);
    build_expected();
    run();
    first_vld = -1; eop_at = -1; nvld = 0;
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
      if (obs[j][3]) begin
        nvld++;
        if (first_vld < 0) first_vld = j;
        if (obs[j][1] && eop_at < 0) eop_at = nvld;
      end
    end
    vectors += 2;
    if (first_vld != 2) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=2", first_vld); end
    if (eop_at != W * H) begin miscompares++; $display("FAIL b2b_eop_index got=%0d exp=%0d", eop_at, W * H); end
  endtask

  task automatic test_gaps();
    stim.delete();
    add_frame(0, 1, H);
    build_expected();
    run();
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL gaps cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
    end
  endtask

  task automatic test_sop_restart();
    stim.delete();
    for (int i = 0; i < 30; i++) add_pix(($urandom_range(0, 1) == 1), (i == 0), 1'b0);
    add_frame(0, 0, H);
    build_expected();
    run();
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL sop_restart cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      din = 1'b1; din_vld = 1'b1; din_sop = (i == 0); din_eop = 1'b0;
    end
    @(posedge clk);
    #2;
    vectors++;
    if (dout_vld !== 1'b1) begin miscompares++; $display("FAIL pre_reset_vld got=%b exp=1", dout_vld); end
    rst_n = 1'b0;
    din_vld = 1'b0; din_sop = 1'b0; din = 1'b0;
    #1;
    vectors++;
    if ({dout, dout_vld, dout_sop, dout_eop} !== 4'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%b exp=0000", {dout, dout_vld, dout_sop, dout_eop});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    stim.delete();
    add_frame(0, 0, H);
    build_expected();
    run();
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
    end
  endtask

  task automatic test_saturate();
    stim.delete();
    add_frame(2, 0, H + 2);
    add_frame(0, 0, H);
    build_expected();
    run();
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL saturate cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
    end
  endtask

  task automatic test_random();
    stim.delete();
    for (int f = 0; f < 4; f++) add_frame(2, 2, H);
    build_expected();
    run();
    foreach (exp_out[j]) begin
      vectors++;
      if (obs[j] !== exp_out[j]) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", j, obs[j], exp_out[j]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_ones();
    test_single_dot();
    test_back_to_back();
    test_gaps();
    test_sop_restart();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_morph.md
BIN_MORPH -- requirements
Module: bin_morph

Interface
REQ-001 Parameter IMG_W, default 640: active pixels per line.
REQ-002 Parameter IMG_H, default 480: active lines per frame.
REQ-003 Port clk, input, 1: pixel clock; the single clock domain.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port din, input, 1: binary pixel from the bin stage.
REQ-006 Port din_vld, input, 1: din valid this cycle.
REQ-007 Port din_sop, input, 1: marks pixel (0,0); qualified by din_vld.
REQ-008 Port din_eop, input, 1: marks pixel (IMG_H-1,IMG_W-1); qualified by din_vld.
REQ-009 Port dout, output, 1: morphology result, to the sobel stage.
REQ-010 Port dout_vld, output, 1: dout valid.
REQ-011 Port dout_sop, output, 1: start of output frame.
REQ-012 Port dout_eop, output, 1: end of output frame.

Function
REQ-013 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing only on din_vld.
REQ-014 On a din_vld pixel, col SHALL wrap from IMG_W-1 to 0 and increment row.
REQ-015 A din_vld&&din_sop pixel SHALL be treated as (0,0), even mid-frame: counters restart and the previous frame is abandoned.
REQ-016 After a din_vld&&din_eop pixel, the next pixel SHALL be treated as (0,0), regardless of counter values.
REQ-017 Two IMG_W x 1-bit line buffers SHALL hold rows row-1 and row-2, written and read at address col only on din_vld.
REQ-018 A 3x3 window SHALL shift one column only on din_vld; it SHALL hold unchanged when din_vld=0.
REQ-019 For input pixel (r,c), the operation SHALL be computed over rows r-2..r and columns c-2..c.
REQ-020 Erosion (default) SHALL give the AND of all 9 window bits.
REQ-021 If r<2 or c<2, dout SHALL be 0; output frame size SHALL equal input size.
REQ-022 dout_vld, dout_sop and dout_eop SHALL be exactly din_vld, din_sop and din_eop delayed 2 clk; input gaps are preserved and there is no backpressure.
REQ-023 dout SHALL be 0 whenever dout_vld=0.
REQ-024 If a frame has more than IMG_H lines without eop, row SHALL saturate at IMG_H-1 and the stage SHALL keep processing.

Reset
REQ-025 While rst_n=0, dout, dout_vld, dout_sop, dout_eop, counters, window and pipeline registers SHALL be 0 immediately (asynchronous).
REQ-026 Line-buffer RAM SHALL NOT be reset; stale contents SHALL be masked by REQ-021.
REQ-027 After release, the first din_vld pixel SHALL be treated as (0,0).

Configuration
REQ-028 With macro BIN_MORPH_DILATE_EN defined, dout SHALL be the OR of the 9 window bits (dilation) instead of AND; border, latency and framing SHALL be unchanged.
REQ-029 Without BIN_MORPH_DILATE_EN, the block SHALL perform erosion only, and no OR logic SHALL be synthesized.

Verification (IMG_W=8, IMG_H=6)
REQ-030 All-ones frame, erosion: 48 dout_vld pulses; dout=0 for r<2 or c<2, else 1 (24 ones).
REQ-031 Single 1 at (3,3), rest 0: erosion gives all-zero output; with DILATE_EN, dout=1 exactly at r,c in {3,4,5}x{3,4,5} (9 ones).
REQ-032 Back-to-back frame with din_vld at cycle N: dout_vld at N+2, dout_sop at first output, dout_eop at 48th output.
REQ-033 din_vld every other cycle, same data as REQ-030: identical dout sequence, gaps preserved 2 clk later.
REQ-034 rst_n low at pixel 20 for 3 clk: all outputs 0 at once; next sop frame matches REQ-030 exactly.
REQ-035 din_sop reasserted at pixel 30 of a frame: counters restart; the following 48 pixels match REQ-030.
